// File: rtl/fetch_decode.sv
// Multicycle front end for `core`: owns the PC, fetches over a req/valid handshake and
// decodes the held instruction into register fields, immediate and control strobes.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        is_zero,
  input  logic [31:0] Da,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] immediate,
  output logic [31:0] new_PC,
  output logic [1:0]  regdst,
  output logic [2:0]  ALUcntrl,
  output logic        AlUsrc,
  output logic        MemWr,
  output logic        RegWr,
  output logic [1:0]  MemtoReg,
  output logic [31:0] pc,
  output logic        halt
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluXor = 3'd2;
  localparam logic [2:0] AluSlt = 3'd3;

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  logic        dec_legal;
  logic [1:0]  dec_regdst;
  logic [2:0]  dec_alu;
  logic        dec_src;
  logic        dec_memwr;
  logic        dec_regwr;
  logic [1:0]  dec_m2r;
  logic [31:0] next_pc;
  logic        in_exec;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    dec_legal  = 1'b0;
    dec_regdst = 2'd0;
    dec_alu    = AluAdd;
    dec_src    = 1'b0;
    dec_memwr  = 1'b0;
    dec_regwr  = 1'b0;
    dec_m2r    = 2'd0;
    next_pc    = pc_plus4;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd: begin
            dec_legal = 1'b1;
            dec_regwr = 1'b1;
            dec_alu   = AluAdd;
          end
          FnSub: begin
            dec_legal = 1'b1;
            dec_regwr = 1'b1;
            dec_alu   = AluSub;
          end
          FnSlt: begin
            dec_legal = 1'b1;
            dec_regwr = 1'b1;
            dec_alu   = AluSlt;
          end
          FnJr: begin
            dec_legal = 1'b1;
            next_pc   = Da;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OpAddi, OpXori: begin
        dec_legal  = 1'b1;
        dec_regdst = 2'd1;
        dec_src    = 1'b1;
        dec_regwr  = 1'b1;
        dec_alu    = (opcode == OpXori) ? AluXor : AluAdd;
      end
      OpLw: begin
        dec_legal  = 1'b1;
        dec_regdst = 2'd1;
        dec_src    = 1'b1;
        dec_m2r    = 2'd1;
        dec_regwr  = 1'b1;
      end
      OpSw: begin
        dec_legal = 1'b1;
        dec_src   = 1'b1;
        dec_memwr = 1'b1;
      end
      OpBeq, OpBne: begin
        dec_legal = 1'b1;
        dec_alu   = AluSub;
        // BEQ takes on zero, BNE on non-zero; opcode bit 0 selects which.
        if (is_zero ^ opcode[0]) next_pc = br_target;
      end
      OpJ: begin
        dec_legal = 1'b1;
        next_pc   = j_target;
      end
      OpJal: begin
        dec_legal  = 1'b1;
        dec_regdst = 2'd2;
        dec_m2r    = 2'd2;
        dec_regwr  = 1'b1;
        next_pc    = j_target;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_regdst = 2'd0;
      dec_alu    = AluAdd;
      dec_src    = 1'b0;
      dec_memwr  = 1'b0;
      dec_regwr  = 1'b0;
      dec_m2r    = 2'd0;
      next_pc    = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (dec_legal) begin
            pc_q    <= next_pc;
            state_q <= StFetch;
          end else begin
            state_q <= StHalt;
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Reset gates the strobes combinationally so none is seen at the reset edge.
  assign in_exec   = (state_q == StExec) && !reset;
  assign imem_req  = (state_q == StFetch) && !reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign new_PC    = pc_plus4;
  assign halt      = (state_q == StHalt);

  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign immediate = ir_q[15:0];

  assign regdst    = in_exec ? dec_regdst : 2'd0;
  assign ALUcntrl  = in_exec ? dec_alu : 3'd0;
  assign AlUsrc    = in_exec & dec_src;
  assign MemWr     = in_exec & dec_memwr;
  assign RegWr     = in_exec & dec_regwr;
  assign MemtoReg  = in_exec ? dec_m2r : 2'd0;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: a table of instructions walked from reset, plus
// hand sequences for fetch stalls, halt, and reset during EXEC.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        is_zero;
  logic [31:0] Da;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic [31:0] new_PC;
  logic [1:0]  regdst;
  logic [2:0]  ALUcntrl;
  logic        AlUsrc, MemWr, RegWr;
  logic [1:0]  MemtoReg;
  logic [31:0] pc;
  logic        halt;

  always #5 clk = ~clk;

  fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .is_zero(is_zero), .Da(Da),
    .rs(rs), .rt(rt), .rd(rd), .immediate(immediate), .new_PC(new_PC), .regdst(regdst),
    .ALUcntrl(ALUcntrl), .AlUsrc(AlUsrc), .MemWr(MemWr), .RegWr(RegWr),
    .MemtoReg(MemtoReg), .pc(pc), .halt(halt)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [31:0] da;
    logic [1:0]  regdst;
    logic [2:0]  alu;
    logic        src;
    logic        memwr;
    logic        regwr;
    logic [1:0]  m2r;
    logic        legal;
    logic [31:0] next_pc;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vec [NumVec];

  int n_tests = 0;
  int n_fail  = 0;
  int regwr_pulses = 0;
  logic [31:0] exp_pc;

  always @(negedge clk) if (RegWr === 1'b1) regwr_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_valid = 1'b0;
    imem_data = 32'd0;
    is_zero = 1'b0;
    Da = 32'd0;
    tick();
    tick();
    check("rst_req", imem_req, 0);
    check("rst_regwr", RegWr, 0);
    check("rst_memwr", MemWr, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_newpc", new_PC, 32'h4);
    check("rst_halt", halt, 0);
    check("rst_fields", {rs, rt, rd, immediate}, 0);
    check("rst_selects", {regdst, ALUcntrl, AlUsrc, MemtoReg}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_req", imem_req, 1);
    exp_pc = 32'h0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vec[i];
    check($sformatf("v%0d_fetch_req", i), imem_req, 1);
    check($sformatf("v%0d_fetch_addr", i), imem_addr, exp_pc);
    check($sformatf("v%0d_fetch_strobes", i), {RegWr, MemWr}, 0);
    imem_valid = 1'b1;
    imem_data = v.instr;
    tick();
    imem_valid = 1'b0;
    imem_data = 32'hDEAD_BEEF;
    is_zero = v.zero;
    Da = v.da;
    #1;
    check($sformatf("v%0d_rs", i), rs, v.instr[25:21]);
    check($sformatf("v%0d_rt", i), rt, v.instr[20:16]);
    check($sformatf("v%0d_rd", i), rd, v.instr[15:11]);
    check($sformatf("v%0d_imm", i), immediate, v.instr[15:0]);
    check($sformatf("v%0d_regdst", i), regdst, v.regdst);
    check($sformatf("v%0d_alu", i), ALUcntrl, v.alu);
    check($sformatf("v%0d_alusrc", i), AlUsrc, v.src);
    check($sformatf("v%0d_memwr", i), MemWr, v.memwr);
    check($sformatf("v%0d_regwr", i), RegWr, v.regwr);
    check($sformatf("v%0d_memtoreg", i), MemtoReg, v.m2r);
    check($sformatf("v%0d_newpc", i), new_PC, exp_pc + 32'd4);
    check($sformatf("v%0d_exec_req", i), imem_req, 0);
    tick();
    check($sformatf("v%0d_next_pc", i), pc, v.next_pc);
    check($sformatf("v%0d_halt", i), halt, !v.legal);
    exp_pc = v.next_pc;
  endtask

  initial begin
    int base;
    //           instr         z  da            rdst alu src mw rw m2r lg next
    vec[0]  = '{32'h2001_0005, 0, 32'h0,        1,   0,  1,  0, 1, 0,  1, 32'h04};
    vec[1]  = '{32'h0021_1020, 0, 32'h0,        0,   0,  0,  0, 1, 0,  1, 32'h08};
    vec[2]  = '{32'h0022_1822, 1, 32'h0,        0,   1,  0,  0, 1, 0,  1, 32'h0C};
    vec[3]  = '{32'h0022_182a, 0, 32'h0,        0,   3,  0,  0, 1, 0,  1, 32'h10};
    vec[4]  = '{32'h1000_FFFC, 1, 32'h0,        0,   1,  0,  0, 0, 0,  1, 32'h04};
    vec[5]  = '{32'h3803_00FF, 0, 32'h0,        1,   2,  1,  0, 1, 0,  1, 32'h08};
    vec[6]  = '{32'h8C04_0010, 0, 32'h0,        1,   0,  1,  0, 1, 1,  1, 32'h0C};
    vec[7]  = '{32'hAC04_0010, 0, 32'h0,        0,   0,  1,  1, 0, 0,  1, 32'h10};
    vec[8]  = '{32'h1000_FFFC, 0, 32'h0,        0,   1,  0,  0, 0, 0,  1, 32'h14};
    vec[9]  = '{32'h0800_0004, 0, 32'h0,        0,   0,  0,  0, 0, 0,  1, 32'h10};
    vec[10] = '{32'h1400_FFFC, 0, 32'h0,        0,   1,  0,  0, 0, 0,  1, 32'h04};
    vec[11] = '{32'h0800_0004, 0, 32'h0,        0,   0,  0,  0, 0, 0,  1, 32'h10};
    vec[12] = '{32'h1400_FFFC, 1, 32'h0,        0,   1,  0,  0, 0, 0,  1, 32'h14};
    vec[13] = '{32'h0800_0040, 0, 32'h0,        0,   0,  0,  0, 0, 0,  1, 32'h100};
    vec[14] = '{32'h0C00_0040, 0, 32'h0,        2,   0,  0,  0, 1, 2,  1, 32'h100};
    vec[15] = '{32'h0020_0008, 0, 32'h200,      0,   0,  0,  0, 0, 0,  1, 32'h200};
    vec[16] = '{32'h0020_0008, 0, 32'hFFFF_FFFC, 0,  0,  0,  0, 0, 0,  1, 32'hFFFF_FFFC};
    vec[17] = '{32'h2001_0005, 0, 32'h0,        1,   0,  1,  0, 1, 0,  1, 32'h0};
    vec[18] = '{32'hFC00_0000, 0, 32'h0,        0,   0,  0,  0, 0, 0,  0, 32'h0};

    // ADDI then ADD with imem_valid held high: two RegWr cycles, pc=8 after 4 edges.
    do_reset();
    base = regwr_pulses;
    imem_valid = 1'b1;
    imem_data = 32'h2001_0005;
    tick();
    imem_data = 32'h0021_1020;
    tick();
    tick();
    tick();
    check("prog_pc", pc, 32'h8);
    imem_valid = 1'b0;
    tick();
    tick();
    check("prog_regwr_pulses", regwr_pulses - base, 2);

    // Fetch stall: address stable, no strobes, EXEC the cycle after valid rises.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, 32'h0);
      check("stall_strobes", {RegWr, MemWr}, 0);
      tick();
    end
    imem_valid = 1'b1;
    imem_data = 32'hAC04_0010;
    tick();
    imem_valid = 1'b0;
    #1;
    check("stall_exec_memwr", MemWr, 1);
    tick();
    check("stall_pc", pc, 32'h4);

    // Main table, walked from reset; ends on an illegal opcode.
    do_reset();
    for (int i = 0; i < NumVec; i++) run_vec(i);

    // Halt holds regardless of imem_valid.
    imem_valid = 1'b1;
    imem_data = 32'h2001_0005;
    for (int c = 0; c < 5; c++) begin
      check("halt_flag", halt, 1);
      check("halt_req", imem_req, 0);
      check("halt_strobes", {RegWr, MemWr}, 0);
      check("halt_pc", pc, 32'h0);
      tick();
    end

    // Illegal funct also halts.
    do_reset();
    imem_valid = 1'b1;
    imem_data = 32'h0000_0001;
    tick();
    imem_valid = 1'b0;
    #1;
    check("badfn_strobes", {RegWr, MemWr}, 0);
    tick();
    check("badfn_halt", halt, 1);
    check("badfn_pc", pc, 32'h0);

    // Reset during EXEC of a writing instruction, away from PC 0.
    do_reset();
    imem_valid = 1'b1;
    imem_data = 32'h0800_0040;
    tick();
    imem_valid = 1'b0;
    tick();
    imem_valid = 1'b1;
    imem_data = 32'h2001_0005;
    tick();
    imem_valid = 1'b0;
    #1;
    check("mid_exec_regwr", RegWr, 1);
    check("mid_exec_pc", pc, 32'h100);
    reset = 1'b1;
    #1;
    check("mid_rst_regwr", RegWr, 0);
    check("mid_rst_req", imem_req, 0);
    tick();
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_halt", halt, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_fetch", imem_req, 1);
    check("mid_rst_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction-fetch and control unit that drives the `core` datapath: it owns the program counter, fetches each instruction from instruction memory over a req/valid handshake, and decodes it into the register fields, immediate and control strobes that `core` consumes. It samples `core`'s `is_zero` and `Da` outputs to resolve branches and `JR`. The result is a multicycle CPU front end with a minimum of 2 cycles per instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= PC)
- imem_valid  in  1  instruction-memory response valid
- imem_data  in  32  instruction word, sampled when imem_valid=1 in FETCH
- is_zero  in  1  ALU-result-zero flag from `core`
- Da  in  32  register file port A (rs) from `core`
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- immediate  out  16  IR[15:0]
- new_PC  out  32  PC+4, used as the JAL link value
- regdst  out  2  0=rd, 1=rt, 2=r31
- ALUcntrl  out  3  0=ADD, 1=SUB, 2=XOR, 3=SLT
- AlUsrc  out  1  0=rt data, 1=sign-extended immediate
- MemWr, RegWr  out  1 each  write strobes, asserted only in EXEC
- MemtoReg  out  2  0=ALU, 1=memory, 2=new_PC
- pc  out  32  current PC
- halt  out  1  high in HALT

## Operation
- States: FETCH, EXEC, HALT. Reset puts the unit in FETCH with PC=RESET_PC and IR=0.
- FETCH
  - imem_req=1 and imem_addr=PC, both held stable until the handshake completes.
  - On a rising edge with imem_valid=1: IR←imem_data, go to EXEC.
  - Otherwise stay in FETCH.
- EXEC
  - Decode outputs are combinational from IR; strobes fire exactly once per instruction.
  - Legal instruction: PC←next PC at the edge, go to FETCH.
  - Illegal opcode or funct: strobes forced to 0, PC unchanged, go to HALT.
- HALT: all strobes 0, imem_req=0. Only reset exits.
- Decode (opcode / funct):
  - R-type 0x00, funct ADD 0x20, SUB 0x22, SLT 0x2a: regdst=0, AlUsrc=0, RegWr=1, MemtoReg=0, ALUcntrl=0/1/3.
  - R-type 0x00, funct JR 0x08: no writes; next PC = Da.
  - ADDI 0x08, XORI 0x0e: regdst=1, AlUsrc=1, RegWr=1, ALUcntrl=0/2. The XORI immediate is sign-extended by `core`.
  - LW 0x23: regdst=1, AlUsrc=1, ALUcntrl=0, MemtoReg=1, RegWr=1.
  - SW 0x2b: AlUsrc=1, ALUcntrl=0, MemWr=1.
  - BEQ 0x04, BNE 0x05: AlUsrc=0, ALUcntrl=1, no writes.
    - Taken when is_zero=1 (BEQ) or is_zero=0 (BNE).
    - Target = PC+4 + (sext(imm)<<2).
  - J 0x02: next PC = {PC+4[31:28], IR[25:0], 2'b00}.
  - JAL 0x03: same next PC as J, plus regdst=2, MemtoReg=2, RegWr=1.
- Default next PC is PC+4. All PC arithmetic is modulo 2^32: wrap from 32'hFFFF_FFFC to 0, negative branch offsets wrap.
- Outside EXEC:
  - RegWr=MemWr=0, ALUcntrl=0, AlUsrc=0, regdst=0, MemtoReg=0.
  - rs/rt/rd/immediate still reflect IR.

## Timing
- Reset
  - Sampled at the rising edge; it dominates every state, including mid-EXEC and mid-handshake.
  - While reset=1, imem_req, RegWr and MemWr are combinationally 0, so no write strobe is seen at the edge where reset is sampled.
  - Reset values: pc=RESET_PC, halt=0, imem_addr=RESET_PC, new_PC=RESET_PC+4, all strobes and selects 0, rs/rt/rd/immediate=0.
- Fetch latency: 1 cycle in FETCH when imem_valid is already high, plus 1 cycle per cycle of imem_valid=0.
- Throughput: minimum 2 cycles per instruction.
- imem_valid outside FETCH is ignored.
- is_zero and Da are sampled at the end of EXEC. They must settle within that cycle, because `core`'s path is combinational from these decode outputs.
- Register and memory writes in `core` occur at the same edge that updates PC.
- JR uses the pre-write Da. JAL writes r31 with PC+4 of the JAL itself.

## Test plan
- Reset, then imem_valid=1 constantly. Program: ADDI r1,r0,5; ADD r2,r1,r1.
  - imem_req=1 with imem_addr=0 in the first cycle after reset.
  - RegWr pulses exactly 2 times, 1 cycle each.
  - pc=8 after 4 cycles.
- Hold imem_valid=0 for 3 cycles in FETCH.
  - imem_addr stays stable; no strobes.
  - EXEC is entered on the cycle after imem_valid=1.
- BEQ at PC=0x10 with imm=0xFFFC:
  - With is_zero=1: next pc=0x04.
  - With is_zero=0: next pc=0x14.
  - BNE gives the inverse result.
- JAL at PC=0x100, target field 0x40:
  - regdst=2, MemtoReg=2, RegWr=1, new_PC=0x104, next pc=0x100.
- JR with Da=0x200: next pc=0x200. At PC=32'hFFFF_FFFC a non-branch instruction wraps pc to 0.
- Illegal opcode 0x3F: halt=1, no strobes, imem_req=0 indefinitely. Asserting reset mid-EXEC gives pc=RESET_PC and no write strobe.
